// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline memory stage.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/buffer4.sv
// MEM/WB pipeline register: loads a full result or a bubble that
// clears the write-back controls.
module buffer4
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_rd_we,
    input  logic              i_regwrite,
    input  logic              i_memtoreg,
    input  logic [WORD_W-1:0] i_readdata,
    input  logic [WORD_W-1:0] i_alures,
    input  logic [REG_W-1:0]  i_wreg,
    output logic              o_regwrite,
    output logic              o_memtoreg,
    output logic [WORD_W-1:0] o_readdata,
    output logic [WORD_W-1:0] o_alures,
    output logic [REG_W-1:0]  o_wreg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_regwrite <= 1'b0;
            o_memtoreg <= 1'b0;
            o_readdata <= '0;
            o_alures   <= '0;
            o_wreg     <= '0;
        end else if (i_load) begin
            o_regwrite <= i_regwrite;
            o_memtoreg <= i_memtoreg;
            o_alures   <= i_alures;
            o_wreg     <= i_wreg;
            // Read data only changes when a load completes.
            if (i_rd_we) begin
                o_readdata <= i_readdata;
            end
        end else begin
            o_regwrite <= 1'b0;
            o_memtoreg <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses with a two-state FSM,
// stalls the front end while waiting, and resolves branches and jumps.
module mem_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              Jump,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              Branch,
    input  logic              zflag,
    input  logic [WORD_W-1:0] JumpV,
    input  logic [WORD_W-1:0] OutBranch,
    input  logic [WORD_W-1:0] AluRes,
    input  logic [WORD_W-1:0] Data2,
    input  logic [REG_W-1:0]  writeReg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              stall,
    output logic              PCSrc,
    output logic [WORD_W-1:0] PCTarget,
    output logic              err_misalign,
    output logic              sal_RegWrite,
    output logic              sal_MemtoReg,
    output logic [WORD_W-1:0] sal_ReadData,
    output logic [WORD_W-1:0] sal_AluRes,
    output logic [REG_W-1:0]  sal_writeReg
);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic              w_access;
    logic              w_memop;
    logic              w_misop;
    logic              w_idle;
    logic              w_done;

    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_we;
    logic              r_memtoreg;
    logic              r_regwrite;
    logic [REG_W-1:0]  r_wreg;
    logic              r_err;

    logic              w_load;
    logic              w_rd_we;
    logic              w_regwrite;
    logic              w_memtoreg;
    logic [WORD_W-1:0] w_alures;
    logic [REG_W-1:0]  w_wreg;

    assign w_access = MemRead | MemWrite;
    assign w_memop  = w_access & (AluRes[1:0] == 2'b00);
    assign w_misop  = w_access & (AluRes[1:0] != 2'b00);
    assign w_idle   = (r_state == IDLE);
    assign w_done   = (r_state == WAIT) & dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_memop) w_state_next = WAIT;
            WAIT:    if (dmem_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Access registers hold the request stable for the whole WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
        end else if (w_idle && w_memop) begin
            r_addr     <= AluRes;
            r_wdata    <= Data2;
            r_we       <= MemWrite;
            r_memtoreg <= MemtoReg;
            r_regwrite <= RegWrite;
            r_wreg     <= writeReg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_idle & w_misop;
        end
    end

    assign dmem_req     = (r_state == WAIT);
    assign dmem_we      = dmem_req & r_we;
    assign dmem_addr    = r_addr;
    assign dmem_wdata   = r_wdata;
    assign err_misalign = r_err;
    assign stall        = (w_idle & w_memop) | ((r_state == WAIT) & ~dmem_ready);
    assign PCSrc        = w_idle & ((Branch & zflag) | Jump);
    assign PCTarget     = Jump ? JumpV : OutBranch;

    always_comb begin
        w_load     = 1'b0;
        w_rd_we    = 1'b0;
        w_regwrite = RegWrite;
        w_memtoreg = MemtoReg;
        w_alures   = AluRes;
        w_wreg     = writeReg;
        if (w_done) begin
            w_load     = 1'b1;
            w_rd_we    = ~r_we;
            w_regwrite = r_regwrite & ~r_we;
            w_memtoreg = r_memtoreg;
            w_alures   = r_addr;
            w_wreg     = r_wreg;
        end else if (w_idle && !w_access) begin
            w_load = 1'b1;
        end
    end

    buffer4 u_buffer4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_rd_we    (w_rd_we),
        .i_regwrite (w_regwrite),
        .i_memtoreg (w_memtoreg),
        .i_readdata (dmem_rdata),
        .i_alures   (w_alures),
        .i_wreg     (w_wreg),
        .o_regwrite (sal_RegWrite),
        .o_memtoreg (sal_MemtoReg),
        .o_readdata (sal_ReadData),
        .o_alures   (sal_AluRes),
        .o_wreg     (sal_writeReg)
    );

endmodule
